instruction_fetch_stage: RTL

- Fetch stage of the processor pipeline. Holds the PC, issues word requests to instruction memory, and registers the returned instruction into the IF/ID output.
- Exports the raw 16-bit immediate field, which feeds the downstream signextension stage, together with the instruction, PC and PC+4.
- Handles downstream stall (with a one-entry skid buffer), branch redirect and flush.

---
 rtl/instruction_fetch_stage.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// instruction_fetch_stage : PC, instruction-memory requests, IF/ID register
// with a one-entry skid buffer, branch redirect and flush.
// Revision 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
  parameter int                  ADDRSize    = 32,
  parameter int                  INSTRSize   = 32,
  parameter int                  IMMSize     = 16,
  parameter logic [ADDRSize-1:0] RESETVector = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  output logic                 imem_req_o,
  output logic [ADDRSize-1:0]  imem_addr_o,
  input  logic                 imem_ready_i,
  input  logic [INSTRSize-1:0] imem_data_i,
  input  logic                 stall_i,
  input  logic                 branch_taken_i,
  input  logic [ADDRSize-1:0]  branch_target_i,
  output logic                 valid_o,
  output logic [INSTRSize-1:0] instr_o,
  output logic [IMMSize-1:0]   imm_o,
  output logic [ADDRSize-1:0]  pc_out_o,
  output logic [ADDRSize-1:0]  pc_plus4_o
);

  localparam logic [ADDRSize-1:0] c_PC_STEP = {{(ADDRSize-3){1'b0}}, 3'b100};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SKID  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDRSize-1:0]    pc_q, pc_d;
  logic [ADDRSize-1:0]    drain_addr_q, drain_addr_d;
  logic                   valid_q, valid_d;
  logic [INSTRSize-1:0]   instr_q, instr_d;
  logic [IMMSize-1:0]     imm_q, imm_d;
  logic [ADDRSize-1:0]    pc_out_q, pc_out_d;
  logic [ADDRSize-1:0]    pc_plus4_q, pc_plus4_d;
  logic [INSTRSize-1:0]   skid_instr_q, skid_instr_d;
  logic [ADDRSize-1:0]    skid_pc_q, skid_pc_d;

  logic [ADDRSize-1:0]    w_target;
  logic [ADDRSize-1:0]    w_pc_inc;
  logic [ADDRSize-1:0]    w_skid_inc;
  logic                   w_accept;
  logic                   w_unused_target_lsbs;

  // Targets are forced onto a word boundary; the two low bits are dropped.
  assign w_target             = {branch_target_i[ADDRSize-1:2], 2'b00};
  assign w_unused_target_lsbs = &{1'b0, branch_target_i[1:0]};
  assign w_pc_inc             = pc_q + c_PC_STEP;
  assign w_skid_inc           = skid_pc_q + c_PC_STEP;

  // While draining, the address must stay on the abandoned request.
  assign imem_req_o  = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr_o = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign w_accept    = imem_ready_i && imem_req_o && (!valid_q || !stall_i);

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign imm_o      = imm_q;
  assign pc_out_o   = pc_out_q;
  assign pc_plus4_o = pc_plus4_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    imm_d        = imm_q;
    pc_out_d     = pc_out_q;
    pc_plus4_d   = pc_plus4_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (branch_taken_i) begin
      valid_d      = 1'b0;
      skid_instr_d = '0;
      skid_pc_d    = '0;
      pc_d         = w_target;
      case (state_q)
        S_FETCH: begin
          if (!imem_ready_i) begin
            state_d      = S_DRAIN;
            drain_addr_d = pc_q;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DRAIN: if (imem_ready_i) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (w_accept) begin
            valid_d    = 1'b1;
            instr_d    = imem_data_i;
            imm_d      = imem_data_i[IMMSize-1:0];
            pc_out_d   = pc_q;
            pc_plus4_d = w_pc_inc;
            pc_d       = w_pc_inc;
          end else if (imem_ready_i && stall_i) begin
            // Response arrived while the output is still held: park it.
            skid_instr_d = imem_data_i;
            skid_pc_d    = pc_q;
            pc_d         = w_pc_inc;
            state_d      = S_SKID;
          end else if (!stall_i) begin
            valid_d = 1'b0;
          end
        end
        S_SKID: begin
          if (!stall_i) begin
            valid_d      = 1'b1;
            instr_d      = skid_instr_q;
            imm_d        = skid_instr_q[IMMSize-1:0];
            pc_out_d     = skid_pc_q;
            pc_plus4_d   = w_skid_inc;
            skid_instr_d = '0;
            skid_pc_d    = '0;
            state_d      = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_ready_i) state_d = S_FETCH;
          if (!stall_i) valid_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      pc_q         <= RESETVector;
      drain_addr_q <= '0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      imm_q        <= '0;
      pc_out_q     <= '0;
      pc_plus4_q   <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      imm_q        <= imm_d;
      pc_out_q     <= pc_out_d;
      pc_plus4_q   <= pc_plus4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule

`default_nettype wire
